// File: rtl/sw_pio_pkg.sv
// Shared register map and control-bit layout for the switch PIO with interrupt.
package sw_pio_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd1;
    localparam logic [1:0] ADDR_EDGE = 2'd2;
    localparam logic [1:0] ADDR_CTRL = 2'd3;

    localparam int CTRL_RISE_EN = 0;
    localparam int CTRL_FALL_EN = 1;
    localparam int CTRL_DB_EN   = 2;
    localparam int CTRL_W       = 3;

    // Rising-edge capture with debounce enabled out of reset.
    localparam logic [CTRL_W-1:0] CTRL_RESET = 3'b101;

    // Edges enabled by the capture controls for one cycle of stable/prev.
    function automatic logic edge_set(input logic cur, input logic prev,
                                      input logic rise_en, input logic fall_en);
        return (cur & ~prev & rise_en) | (~cur & prev & fall_en);
    endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch input: multi-flop synchroniser followed by a stability counter that
// accepts a new level only after it has persisted for DEBOUNCE_CYCLES clocks.
module sw_debounce_bit #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    input  logic db_en,
    output logic stable
);

    localparam int CNT_W = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic [CNT_W-1:0]       cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], raw};
        end
    end

    assign s = sync[SYNC_STAGES-1];

    // A level that falls back to the accepted state restarts the count from zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (!db_en) begin
            cnt    <= '0;
            stable <= s;
        end else if (s == stable) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt    <= '0;
            stable <= s;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sw_pio_irq.sv
// Avalon-MM switch port: per-bit debounce, configurable edge capture with
// write-1-to-clear, and a registered level interrupt gated by a mask.
module sw_pio_irq
    import sw_pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] sw_in,
    output logic             irq
);

    logic [WIDTH-1:0]  stable;
    logic [WIDTH-1:0]  prev;
    logic [WIDTH-1:0]  mask;
    logic [WIDTH-1:0]  cap;
    logic [WIDTH-1:0]  set;
    logic [WIDTH-1:0]  clr;
    logic [CTRL_W-1:0] ctrl;
    logic [31:0]       rdata_next;
    logic              wr_en;
    logic              rd_en;
    logic              unused_wdata;

    assign wr_en        = chipselect & write;
    assign rd_en        = chipselect & read;
    assign unused_wdata = ^writedata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sw_debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_db (
            .clk     (clk),
            .reset_n (reset_n),
            .raw     (sw_in[i]),
            .db_en   (ctrl[CTRL_DB_EN]),
            .stable  (stable[i])
        );
    end

    always_comb begin
        set = '0;
        clr = '0;
        for (int i = 0; i < WIDTH; i++) begin
            set[i] = edge_set(stable[i], prev[i], ctrl[CTRL_RISE_EN], ctrl[CTRL_FALL_EN]);
        end
        if (wr_en && address == ADDR_EDGE) begin
            clr = writedata[WIDTH-1:0];
        end
    end

    always_comb begin
        rdata_next = '0;
        case (address)
            ADDR_DATA: rdata_next[WIDTH-1:0]  = stable;
            ADDR_MASK: rdata_next[WIDTH-1:0]  = mask;
            ADDR_EDGE: rdata_next[WIDTH-1:0]  = cap;
            ADDR_CTRL: rdata_next[CTRL_W-1:0] = ctrl;
            default:   rdata_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev <= '0;
            cap  <= '0;
            irq  <= 1'b0;
        end else begin
            prev <= stable;
            // A new edge in the same cycle as a clear of that bit stays captured.
            cap  <= (cap & ~clr) | set;
            irq  <= |(cap & mask);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask <= '0;
            ctrl <= CTRL_RESET;
        end else if (wr_en) begin
            if (address == ADDR_MASK) mask <= writedata[WIDTH-1:0];
            if (address == ADDR_CTRL) ctrl <= writedata[CTRL_W-1:0];
        end
    end

    // Register sampled before any same-cycle write lands, so reads see the old value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else if (rd_en) begin
            readdata <= rdata_next;
        end
    end

endmodule

// File: tb/tb_sw_pio_irq.sv
// Directed bench for sw_pio_irq with WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
module tb_sw_pio_irq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [3:0]  sw_in = '0;
    logic        irq;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        do_write;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs [7];
    logic [31:0] rv;
    logic [31:0] rd_hist [1:10];
    logic        irq_hist [1:10];
    int          first_hit;

    sw_pio_irq #(
        .WIDTH           (4),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .read       (read),
        .write      (write),
        .writedata  (writedata),
        .readdata   (readdata),
        .sw_in      (sw_in),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write = 1'b1; read = 1'b0; address = a; writedata = d;
        tick();
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        chipselect = 1'b1; read = 1'b1; write = 1'b0; address = a;
        tick();
        chipselect = 1'b0; read = 1'b0;
        d = readdata;
    endtask

    // Holds a continuous DATA read while the switch change propagates.
    task automatic stream_data(input int n);
        chipselect = 1'b1; read = 1'b1; address = 2'd0;
        for (int i = 1; i <= n; i++) begin
            tick();
            rd_hist[i]  = readdata;
            irq_hist[i] = irq;
        end
        chipselect = 1'b0; read = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b1, 2'd1, 32'h0000_000F, 32'h0000_000F};
        vecs[1] = '{1'b1, 2'd1, 32'hFFFF_FFF5, 32'h0000_0005};
        vecs[2] = '{1'b1, 2'd3, 32'hFFFF_FFFA, 32'h0000_0002};
        vecs[3] = '{1'b1, 2'd3, 32'h0000_0005, 32'h0000_0005};
        vecs[4] = '{1'b1, 2'd0, 32'h0000_000F, 32'h0000_0000};
        vecs[5] = '{1'b1, 2'd2, 32'h0000_000F, 32'h0000_0000};
        vecs[6] = '{1'b1, 2'd1, 32'h0000_0001, 32'h0000_0001};

        // Reset state
        repeat (3) tick();
        check("rst_readdata", readdata, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        reset_n = 1'b1;
        tick();
        bus_read(2'd0, rv); check("rst_data", rv, 32'h0);
        bus_read(2'd3, rv); check("rst_ctrl", rv, 32'h5);
        check("rst_irq_after", {31'b0, irq}, 32'h0);

        // Register access table
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].do_write) bus_write(vecs[i].addr, vecs[i].wdata);
            bus_read(vecs[i].addr, rv);
            check($sformatf("vec%0d", i), rv, vecs[i].exp);
        end

        // Write without chipselect is ignored
        write = 1'b1; address = 2'd1; writedata = 32'hE;
        tick();
        write = 1'b0;
        bus_read(2'd1, rv); check("no_cs_write", rv, 32'h1);

        // Read and write together return the pre-write value
        chipselect = 1'b1; read = 1'b1; write = 1'b1; address = 2'd1; writedata = 32'h3;
        tick();
        chipselect = 1'b0; read = 1'b0; write = 1'b0;
        check("rw_old_value", readdata, 32'h1);
        bus_read(2'd1, rv); check("rw_new_value", rv, 32'h3);
        bus_write(2'd1, 32'h1);

        // Three-cycle glitch on bit0 is rejected
        sw_in = 4'b0001;
        repeat (3) tick();
        sw_in = 4'b0000;
        repeat (10) tick();
        bus_read(2'd0, rv); check("glitch_data", rv, 32'h0);
        bus_read(2'd2, rv); check("glitch_edge", rv, 32'h0);
        check("glitch_irq", {31'b0, irq}, 32'h0);

        // Debounced rise on bit1: DATA after 2+4+1 cycles, irq one cycle after capture
        bus_write(2'd1, 32'h2);
        sw_in = 4'b0010;
        stream_data(10);
        first_hit = 0;
        for (int i = 10; i >= 1; i--) if (rd_hist[i] == 32'h2) first_hit = i;
        check("rise_latency", first_hit, 7);
        check("irq_before", {31'b0, irq_hist[7]}, 32'h0);
        check("irq_rise", {31'b0, irq_hist[8]}, 32'h1);
        bus_read(2'd2, rv); check("rise_edge", rv, 32'h2);

        // Write-1-to-clear: irq falls the cycle after the capture clears
        bus_write(2'd2, 32'h2);
        check("irq_lag", {31'b0, irq}, 32'h1);
        bus_read(2'd2, rv); check("clr_edge", rv, 32'h0);
        check("clr_irq", {31'b0, irq}, 32'h0);

        // Falling-only capture: bit1 falls, bit2 rises
        bus_write(2'd3, 32'h6);
        sw_in = 4'b0100;
        repeat (10) tick();
        bus_read(2'd2, rv); check("fall_edge", rv, 32'h2);
        bus_read(2'd0, rv); check("fall_data", rv, 32'h4);

        // New rise on bit1 lands on the same edge as its clear
        bus_write(2'd3, 32'h7);
        bus_write(2'd2, 32'hF);
        sw_in = 4'b0110;
        repeat (6) tick();
        bus_write(2'd2, 32'h2);
        bus_read(2'd2, rv); check("set_wins", rv, 32'h2);

        // Debounce disabled: DATA follows after sync stages plus one
        bus_write(2'd3, 32'h1);
        bus_write(2'd2, 32'hF);
        sw_in = 4'b1000;
        stream_data(6);
        check("nodb_before", rd_hist[3], 32'h6);
        check("nodb_data", rd_hist[4], 32'h8);
        bus_read(2'd2, rv); check("nodb_edge", rv, 32'h8);

        // Asynchronous reset mid-count
        bus_write(2'd3, 32'h5);
        bus_write(2'd1, 32'hF);
        tick();
        check("pre_rst_irq", {31'b0, irq}, 32'h1);
        sw_in = 4'b0000;
        repeat (2) tick();
        bus_read(2'd2, rv); check("pre_rst_edge", rv, 32'h8);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_readdata", readdata, 32'h0);
        check("async_rst_irq", {31'b0, irq}, 32'h0);
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        bus_read(2'd2, rv); check("post_rst_edge", rv, 32'h0);
        bus_read(2'd3, rv); check("post_rst_ctrl", rv, 32'h5);
        bus_read(2'd1, rv); check("post_rst_mask", rv, 32'h0);
        bus_read(2'd0, rv); check("post_rst_data", rv, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
